// File: rtl/hopfield_stream_driver_pkg.sv
// Shared definitions for the Hopfield stream driver.
// Holds default geometry, the bipolar word constants and the driver FSM encoding.
package hopfield_stream_driver_pkg;

    localparam int unsigned DEF_MEM_WIDTH     = 16;
    localparam int unsigned DEF_IMAGE_WIDTH   = 10;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;

    // Pixels per frame for the default image size
    localparam int unsigned N = DEF_IMAGE_WIDTH * DEF_IMAGE_WIDTH;

    // Bipolar pixel encodings; signed so that resizing sign-extends
    localparam logic signed [DEF_MEM_WIDTH-1:0] POS_ONE = 16'sh0001;
    localparam logic signed [DEF_MEM_WIDTH-1:0] NEG_ONE = 16'shFFFF;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StFit    = 2'd1,
        StSettle = 2'd2,
        StSend   = 2'd3
    } state_e;

endpackage

// File: rtl/hopfield_stream_driver_if.sv
// Interface bundling the pixel streams and the Hopfield core's wide parallel bus.
// Signals:
//   in_valid/in_ready/in_pixel/in_mode   serial input pixel stream (mode sampled on pixel 0)
//   out_valid/out_ready/out_pixel/out_last  serial recalled pixel stream
//   fit_done                             pulse after a store has been issued
//   net_fit/net_image                    fit strobe and flat image bus to the core
//   net_out                              flat recalled state bus from the core
// Modports: master = the driver, slave = the surrounding environment.
interface hopfield_stream_driver_if
    import hopfield_stream_driver_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int unsigned NUM_PIX   = N
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_pixel;
    logic                         in_mode;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_pixel;
    logic                         out_last;
    logic                         fit_done;
    logic                         net_fit;
    logic [MEM_WIDTH*NUM_PIX-1:0] net_image;
    logic [MEM_WIDTH*NUM_PIX-1:0] net_out;

    modport master (
        input  in_valid, in_pixel, in_mode, out_ready, net_out,
        output in_ready, out_valid, out_pixel, out_last, fit_done, net_fit, net_image
    );

    modport slave (
        output in_valid, in_pixel, in_mode, out_ready, net_out,
        input  in_ready, out_valid, out_pixel, out_last, fit_done, net_fit, net_image
    );

endinterface

// File: rtl/hopfield_word_sign.sv
// Selects word idx from a flat bus of signed words and returns its sign-derived pixel:
// 1 when the word is >= 0 (sign bit clear, zero included), 0 when negative.
// Ports:
//   words  in  MEM_WIDTH*NUM_WORDS  flat word bus, word i at [MEM_WIDTH*(i+1)-1 : MEM_WIDTH*i]
//   idx    in  IDX_W                word index
//   pixel  out 1                    sign-derived pixel of the selected word
module hopfield_word_sign #(
    parameter int unsigned MEM_WIDTH = 16,
    parameter int unsigned NUM_WORDS = 100,
    parameter int unsigned IDX_W     = 7
) (
    input  logic [MEM_WIDTH*NUM_WORDS-1:0] words,
    input  logic [IDX_W-1:0]               idx,
    output logic                           pixel
);
    localparam int unsigned BIT_W = $clog2(MEM_WIDTH * NUM_WORDS);

    logic [BIT_W-1:0] msb_pos;

    always_comb begin
        msb_pos = BIT_W'(idx * MEM_WIDTH + MEM_WIDTH - 1);
        pixel   = ~words[msb_pos];
    end

endmodule

// File: rtl/hopfield_stream_driver.sv
// Initiator-side driver for the Hopfield core. Loads a serial 1-bit pixel frame into the
// bipolar image bus, then either strobes fit for one cycle (store) or waits for the core
// to settle, captures its state bus and streams the recalled frame back out.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  hopfield_stream_driver_if.master  pixel streams and core bus
module hopfield_stream_driver
    import hopfield_stream_driver_pkg::*;
#(
    parameter int unsigned MEM_WIDTH     = DEF_MEM_WIDTH,
    parameter int unsigned IMAGE_WIDTH   = DEF_IMAGE_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input logic                      clk,
    input logic                      rst,
    hopfield_stream_driver_if.master bus
);
    localparam int unsigned NUM_PIX = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int unsigned IDX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int unsigned BUS_W   = MEM_WIDTH * NUM_PIX;
    localparam int unsigned BIT_W   = $clog2(BUS_W);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PIX - 1);
    localparam logic [IDX_W-1:0] SETTLE_LAST = IDX_W'(SETTLE_CYCLES - 1);

    state_e             state;
    logic [IDX_W-1:0]   pix_cnt;
    logic [IDX_W-1:0]   settle_cnt;
    logic               mode;
    logic [BUS_W-1:0]   capture;
    logic [BUS_W-1:0]   net_image;
    logic               in_ready;
    logic               out_valid;
    logic               out_pixel;
    logic               out_last;
    logic               fit_done;
    logic               net_fit;

    logic               in_fire;
    logic               cur_mode;
    logic [MEM_WIDTH-1:0] pix_word;
    logic [BIT_W-1:0]   wr_base;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_pixel;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pixel = out_pixel;
    assign bus.out_last  = out_last;
    assign bus.fit_done  = fit_done;
    assign bus.net_fit   = net_fit;
    assign bus.net_image = net_image;

    always_comb begin
        in_fire  = (state == StLoad) && in_ready && bus.in_valid;
        // Mode is only meaningful on pixel 0; later pixels use the latched copy
        cur_mode = (pix_cnt == '0) ? bus.in_mode : mode;
        pix_word = bus.in_pixel ? MEM_WIDTH'(POS_ONE) : MEM_WIDTH'(NEG_ONE);
        wr_base  = BIT_W'(pix_cnt * MEM_WIDTH);
        // Output pixel is registered, so look one word ahead once a pixel is on the bus
        sel_idx  = (out_valid && (pix_cnt != LAST_IDX)) ? pix_cnt + 1'b1 : pix_cnt;
    end

    hopfield_word_sign #(
        .MEM_WIDTH (MEM_WIDTH),
        .NUM_WORDS (NUM_PIX),
        .IDX_W     (IDX_W)
    ) u_word_sign (
        .words (capture),
        .idx   (sel_idx),
        .pixel (sel_pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StLoad;
            pix_cnt    <= '0;
            settle_cnt <= '0;
            mode       <= 1'b0;
            capture    <= '0;
            net_image  <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_pixel  <= 1'b0;
            out_last   <= 1'b0;
            fit_done   <= 1'b0;
            net_fit    <= 1'b0;
        end else begin
            fit_done <= 1'b0;
            unique case (state)
                StLoad: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        net_image[wr_base +: MEM_WIDTH] <= pix_word;
                        if (pix_cnt == '0) begin
                            mode <= bus.in_mode;
                        end
                        if (pix_cnt == LAST_IDX) begin
                            in_ready   <= 1'b0;
                            pix_cnt    <= '0;
                            settle_cnt <= '0;
                            state      <= cur_mode ? StFit : StSettle;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                StFit: begin
                    // First cycle raises the strobe, second drops it and reports done
                    if (!net_fit) begin
                        net_fit <= 1'b1;
                    end else begin
                        net_fit  <= 1'b0;
                        fit_done <= 1'b1;
                        state    <= StLoad;
                    end
                end
                StSettle: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        capture <= bus.net_out;
                        state   <= StSend;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                StSend: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_pixel <= sel_pixel;
                        out_last  <= (sel_idx == LAST_IDX);
                    end else if (bus.out_ready) begin
                        if (pix_cnt == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_pixel <= 1'b0;
                            out_last  <= 1'b0;
                            pix_cnt   <= '0;
                            in_ready  <= 1'b1;
                            state     <= StLoad;
                        end else begin
                            pix_cnt   <= sel_idx;
                            out_pixel <= sel_pixel;
                            out_last  <= (sel_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_hopfield_stream_driver.sv
// Self-checking bench for hopfield_stream_driver: directed frames, expected output pixels
// pushed to a queue at stimulus time and popped by an independent monitor.
module tb_hopfield_stream_driver;
    import hopfield_stream_driver_pkg::*;

    localparam int unsigned MW = 16;
    localparam int unsigned SETTLE = 2;

    typedef struct packed {
        logic pixel;
        logic last;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    exp_t         exp_q[$];
    logic [MW-1:0] exp_word[N];
    int           last_hs;
    int           hs_cnt;
    int           fit_cnt;
    int           done_cnt;
    bit           ready_pat_en;
    bit           started;
    bit           post_last;

    logic [MW*N-1:0] ws_bus;
    logic [6:0]      ws_idx;
    logic            ws_pixel;

    hopfield_stream_driver_if #(.MEM_WIDTH(MW), .NUM_PIX(N)) ifc ();

    hopfield_stream_driver #(
        .MEM_WIDTH     (MW),
        .IMAGE_WIDTH   (10),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    hopfield_word_sign #(.MEM_WIDTH(MW), .NUM_WORDS(N), .IDX_W(7)) u_ws (
        .words (ws_bus),
        .idx   (ws_idx),
        .pixel (ws_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_image(input string name);
        logic [MW*N-1:0] flat;
        int bad;
        bad = -1;
        for (int i = 0; i < N; i++) flat[i*MW +: MW] = exp_word[i];
        checks++;
        if (ifc.net_image !== flat) begin
            errors++;
            for (int i = N - 1; i >= 0; i--) if (ifc.net_image[i*MW +: MW] !== exp_word[i]) bad = i;
            $display("FAIL %s: word %0d got %h expected %h", name, bad,
                     ifc.net_image[bad*MW +: MW], exp_word[bad]);
        end
    endtask

    function automatic bit pix_of(input int kind, input int k);
        case (kind)
            0:       return 1'b1;
            1:       return ((k / 10 + k % 10) % 2) == 0;
            default: return (k % 3) == 0;
        endcase
    endfunction

    // Presents n pixels; each handshake completes on the posedge after in_ready is seen high.
    task automatic drive_frame(input int n, input bit mode, input int kind, input bit toggle);
        for (int k = 0; k < n; k++) begin
            int guard;
            bit px;
            px = pix_of(kind, k);
            ifc.in_valid = 1'b1;
            ifc.in_pixel = px;
            ifc.in_mode  = (k == 0) ? mode : (toggle ? bit'(k % 2) : mode);
            guard = 0;
            while (!ifc.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!ifc.in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1 at pixel %0d", k);
                ifc.in_valid = 1'b0;
                return;
            end
            exp_word[k] = px ? 16'h0001 : 16'hFFFF;
            last_hs = cyc + 1;
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && !ifc.out_valid && ifc.in_ready) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d outputs still expected, got idle 0 expected 1",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: drives out_ready, checks the output stream against the queue, watches fit.
    initial begin
        bit pat[4];
        int ph;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ph = 0;
        ifc.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            ifc.out_ready = ready_pat_en ? pat[ph % 4] : 1'b1;
            ph++;
            if (rst) continue;
            if (post_last) begin
                chk("out_valid_after_last", ifc.out_valid, 0);
                chk("in_ready_after_last", ifc.in_ready, 1);
                post_last = 1'b0;
            end
            if (ifc.net_fit) begin
                fit_cnt++;
                chk("fit_latency", cyc - last_hs, 1);
                chk_image("fit_image");
            end
            if (ifc.fit_done) begin
                done_cnt++;
                chk("fit_done_latency", cyc - last_hs, 2);
            end
            if (ifc.out_valid) begin
                if (!started) begin
                    chk("recall_latency", cyc - last_hs, SETTLE + 1);
                    started = 1'b1;
                end
                chk("in_ready_during_send", ifc.in_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_pixel", ifc.out_pixel, exp_q[0].pixel);
                    chk("out_last", ifc.out_last, exp_q[0].last);
                    if (ifc.out_ready) begin
                        hs_cnt++;
                        if (exp_q[0].last) begin
                            started   = 1'b0;
                            post_last = 1'b1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW*N-1:0] pat;
        int fits0;
        int dones0;
        int guard;

        checks = 0; errors = 0; hs_cnt = 0; fit_cnt = 0; done_cnt = 0; last_hs = 0;
        ready_pat_en = 1'b0; started = 1'b0; post_last = 1'b0;
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_pixel = 1'b0; ifc.in_mode = 1'b0;
        ifc.net_out = '0;
        for (int i = 0; i < N; i++) exp_word[i] = '0;

        // Word-sign selector: zero word gives 1, sign bit set gives 0
        ws_bus = '0;
        ws_bus[6*MW +: MW] = 16'h8000;
        ws_idx = 7'd5;
        #1 chk("word_sign_zero", ws_pixel, 1);
        ws_idx = 7'd6;
        #1 chk("word_sign_neg", ws_pixel, 0);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 0);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_pixel", ifc.out_pixel, 0);
        chk("rst_out_last", ifc.out_last, 0);
        chk("rst_fit_done", ifc.fit_done, 0);
        chk("rst_net_fit", ifc.net_fit, 0);
        chk_image("rst_net_image");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Abort a partial frame with reset, then a full recall frame (alternating core state)
        drive_frame(37, 1'b0, 2, 1'b0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) exp_word[i] = '0;
        chk("midrst_in_ready", ifc.in_ready, 0);
        chk("midrst_net_fit", ifc.net_fit, 0);
        chk_image("midrst_net_image");
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < N; j++) begin
            pat[j*MW +: MW] = (j % 2 == 0) ? 16'h0001 : 16'hFFFF;
            exp_q.push_back('{pixel: (j % 2 == 0), last: (j == N - 1)});
        end
        ifc.net_out = pat;
        hs_cnt = 0;
        drive_frame(N, 1'b0, 2, 1'b0);
        wait_idle();
        chk("recall1_handshakes", hs_cnt, N);

        // Fit frame, all pixels on
        fits0 = fit_cnt; dones0 = done_cnt;
        drive_frame(N, 1'b1, 0, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("fit1_strobes", fit_cnt - fits0, 1);
        chk("fit1_done", done_cnt - dones0, 1);

        // Recall with stalling downstream (ready pattern 1,0,0,1)
        for (int j = 0; j < N; j++) begin
            pat[j*MW +: MW] = (j % 2 == 0) ? 16'hFFFF : 16'h0001;
            exp_q.push_back('{pixel: (j % 2 == 1), last: (j == N - 1)});
        end
        ifc.net_out = pat;
        ready_pat_en = 1'b1;
        hs_cnt = 0;
        drive_frame(N, 1'b0, 2, 1'b0);
        wait_idle();
        ready_pat_en = 1'b0;
        chk("stall_handshakes", hs_cnt, N);

        // Checkerboard fit, then recall where net_out changes after capture
        fits0 = fit_cnt; dones0 = done_cnt;
        drive_frame(N, 1'b1, 1, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("fit2_strobes", fit_cnt - fits0, 1);
        chk("fit2_done", done_cnt - dones0, 1);
        for (int j = 0; j < N; j++) begin
            if (j == 0) pat[j*MW +: MW] = 16'h0000;
            else if (j % 4 < 2) pat[j*MW +: MW] = 16'(j * 100);
            else pat[j*MW +: MW] = 16'(-(j * 100));
            exp_q.push_back('{pixel: (j == 0 || j % 4 < 2), last: (j == N - 1)});
        end
        ifc.net_out = pat;
        hs_cnt = 0;
        drive_frame(N, 1'b0, 2, 1'b0);
        guard = 0;
        while (!ifc.out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("capture_out_valid_seen", ifc.out_valid, 1);
        ifc.net_out = ~pat;
        wait_idle();
        chk("recall2_handshakes", hs_cnt, N);

        // in_mode toggling after pixel 0 is ignored
        fits0 = fit_cnt;
        for (int j = 0; j < N; j++) begin
            pat[j*MW +: MW] = (j < 50) ? 16'h7FFF : 16'h8000;
            exp_q.push_back('{pixel: (j < 50), last: (j == N - 1)});
        end
        ifc.net_out = pat;
        hs_cnt = 0;
        drive_frame(N, 1'b0, 2, 1'b1);
        wait_idle();
        chk("mode_toggle_handshakes", hs_cnt, N);
        chk("mode_toggle_no_fit", fit_cnt - fits0, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hopfield_stream_driver.md
Name: hopfield_stream_driver

Overview:
- Initiator-side driver for the Hopfield core's wide parallel interface (fit strobe, flat image bus, flat recalled-state bus).
- Accepts a serial 1-bit pixel stream with valid/ready and converts each pixel to a bipolar signed word.
- Assembles the flat image bus and either issues a one-cycle fit strobe (store pattern) or lets the core settle for recall.
- On recall, captures the core's state bus and streams it back as 1-bit pixels with valid/ready.

Parameters:
- MEM_WIDTH, 16, signed word width per pixel on the core bus.
- IMAGE_WIDTH, 10, image side length; N = IMAGE_WIDTH*IMAGE_WIDTH pixels per frame.
- SETTLE_CYCLES, 2, clock cycles with fit low before the recalled state is captured (minimum 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  driver accepts an input pixel.
- in_pixel  in  1  pixel value, 1 = on, 0 = off.
- in_mode  in  1  sampled with pixel 0 only: 1 = fit (store), 0 = recall.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts an output pixel.
- out_pixel  out  1  recalled pixel value.
- out_last  out  1  high with pixel N-1 of the output frame.
- fit_done  out  1  one-cycle pulse after the fit strobe has been issued.
- net_fit  out  1  fit strobe to the core.
- net_image  out  MEM_WIDTH*N  flat image bus to the core; word i occupies bits [MEM_WIDTH*(i+1)-1 : MEM_WIDTH*i].
- net_out  in  MEM_WIDTH*N  core state bus, same word layout.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_pixel=0, out_last=0, fit_done=0, net_fit=0, net_image=all zeros. The pixel counter, settle counter, mode and capture register are zeroed, and the FSM enters LOAD.
- Reset asserted mid-operation aborts the frame immediately (async): net_fit drops the same instant, and a partially loaded frame is discarded.
- FSM states: LOAD, FIT, SETTLE, SEND.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready.
  - Pixel k writes word k of net_image: pixel 1 gives +1 (16'h0001), pixel 0 gives -1 (all ones), sign-extended to MEM_WIDTH.
  - in_mode is latched on pixel 0 and ignored afterwards.
  - On pixel N-1: go to FIT if mode=1, else to SETTLE with the settle counter at 0.
  - Untouched words keep their previous frame value (no clear between frames).
- FIT:
  - net_fit=1 for exactly one cycle, with net_image stable and in_ready=0.
  - Next cycle: net_fit=0, fit_done=1 for one cycle, back to LOAD.
  - No output frame is produced.
- SETTLE:
  - in_ready=0, net_fit=0, counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1, register net_out into the capture register and go to SEND.
- SEND:
  - out_valid=1.
  - out_pixel = 1 when capture word j is >= 0 (sign bit 0), else 0.
  - Zero-valued words map to pixel 1.
  - out_last=1 when j=N-1.
  - j advances only on out_valid && out_ready; out_pixel and out_last are held stable while stalled.
  - After the handshake on j=N-1: out_valid=0 next cycle, return to LOAD.
  - No input is accepted during SEND; net_out changes after capture have no effect.
- Latency:
  - Fit frame: last input handshake to net_fit high = 1 cycle; fit_done follows net_fit by 1 cycle.
  - Recall frame: last input handshake to first out_valid = SETTLE_CYCLES+1 cycles.
- Back-to-back frames: in_ready returns the cycle after fit_done, or the cycle after the final output handshake.
- Counters are sized $clog2(N) bits; pixel index never wraps within a frame; reset clears it.

Decomposition:
- Shared package: the N = IMAGE_WIDTH*IMAGE_WIDTH localparam, bipolar constants POS_ONE/NEG_ONE as MEM_WIDTH-wide values, and the FSM state encoding (LOAD=0, FIT=1, SETTLE=2, SEND=3).
- One natural sub-module, hopfield_word_sign: selects word j from a flat bus and returns its sign-derived pixel. It is reused in the bench scoreboard.

Test Plan:
- Reset mid-LOAD after 37 pixels, then a full recall frame -> first out_valid exactly SETTLE_CYCLES+1 cycles after the last in handshake; no stale count is carried over.
- Fit frame with all pixels 1 (mode=1) -> net_image words all 16'h0001; net_fit high exactly 1 cycle, 1 cycle after pixel 99; fit_done 1 cycle later; out_valid never asserts.
- Recall frame, core model returns net_out word j = (j even ? 16'h0001 : 16'hFFFF) -> output stream 1,0,1,0,...; out_last only on pixel 99.
- Recall with out_ready toggling 1,0,0,1 -> out_pixel/out_last are stable during stalls; exactly 100 handshakes; in_ready stays 0 until after the last one.
- Checkerboard fit, then a recall frame; net_out changed after capture -> outputs match the captured values; a zero word yields pixel 1.
- in_mode toggled on pixels 1..99 of a recall frame -> ignored; the frame completes as recall.
